// File: rtl/sprite_anim_renderer.sv
// Animated sprite pixel engine: places a SPR_W x SPR_H sprite, walks its animation
// frames on vsync, and produces keyed palette colour two pixel clocks after DrawX/DrawY.
module sprite_anim_renderer #(
    parameter int SPR_W           = 40,
    parameter int SPR_H           = 40,
    parameter int FRAMES          = 4,
    parameter int FRAME_TICKS     = 6,
    parameter int ADDR_W          = 13,
    parameter int PIX_W           = 4,
    parameter int TRANSPARENT_IDX = 0,
    localparam int FI_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic              blank,
    input  logic              vsync,
    input  logic              play,
    input  logic              loop,
    input  logic              flip,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [PIX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_on,
    output logic [FI_W-1:0]   frame_idx,
    output logic              anim_done
);

    localparam int TICK_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic               r_vsync_d;
    logic               r_flip_lat;
    logic               r_v1, r_b1, r_v2, r_b2;

    logic               w_vs_rise;
    logic [10:0]        w_lx, w_ly, w_cx;
    logic               w_in_box;
    logic [ADDR_W-1:0]  w_addr;

    assign w_vs_rise = vsync & ~r_vsync_d;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            frame_idx  <= '0;
            r_tick     <= '0;
            anim_done  <= 1'b0;
            r_vsync_d  <= 1'b0;
            r_flip_lat <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            if (w_vs_rise)
                r_flip_lat <= flip;
            case (r_state)
                S_IDLE: begin
                    frame_idx <= '0;
                    r_tick    <= '0;
                    anim_done <= 1'b0;
                    if (play)
                        r_state <= S_PLAY;
                end
                S_PLAY: begin
                    if (!play) begin
                        r_state   <= S_IDLE;
                        frame_idx <= '0;
                        r_tick    <= '0;
                    end else if (w_vs_rise) begin
                        if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
                            r_tick <= '0;
                            if (frame_idx == FI_W'(FRAMES - 1)) begin
                                // One-shot holds the last frame and parks in DONE.
                                if (loop) begin
                                    frame_idx <= '0;
                                end else begin
                                    r_state   <= S_DONE;
                                    anim_done <= 1'b1;
                                end
                            end else begin
                                frame_idx <= frame_idx + FI_W'(1);
                            end
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!play) begin
                        r_state   <= S_IDLE;
                        frame_idx <= '0;
                        r_tick    <= '0;
                        anim_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // 11-bit offsets keep DrawX < SprX from aliasing into the box.
    assign w_lx     = {1'b0, DrawX} - {1'b0, SprX};
    assign w_ly     = {1'b0, DrawY} - {1'b0, SprY};
    assign w_in_box = (DrawX >= SprX) && (w_lx < 11'(SPR_W)) &&
                      (DrawY >= SprY) && (w_ly < 11'(SPR_H));
    assign w_cx     = r_flip_lat ? (11'(SPR_W - 1) - w_lx) : w_lx;
    assign w_addr   = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ) +
                      ADDR_W'(w_ly) * ADDR_W'(SPR_W) + ADDR_W'(w_cx);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr  <= '0;
            r_v1      <= 1'b0;
            r_b1      <= 1'b0;
            pal_index <= '0;
            r_v2      <= 1'b0;
            r_b2      <= 1'b0;
        end else begin
            rom_addr  <= w_in_box ? w_addr : '0;
            r_v1      <= w_in_box;
            r_b1      <= blank;
            pal_index <= rom_q;
            r_v2      <= r_v1 && (rom_q != PIX_W'(TRANSPARENT_IDX));
            r_b2      <= r_b1;
        end
    end

    assign sprite_on = r_v2 & r_b2;
    assign red       = sprite_on ? pal_red   : 4'h0;
    assign green     = sprite_on ? pal_green : 4'h0;
    assign blue      = sprite_on ? pal_blue  : 4'h0;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Scoreboard bench for sprite_anim_renderer: directed pixel scans push expected
// rom_addr / colour into queues, a negedge monitor pops and compares.
module tb_sprite_anim_renderer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, SprX, SprY;
    logic        blank, vsync, play, loop, flip;
    logic [12:0] rom_addr;
    logic [3:0]  rom_q, pal_index, pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;
    logic        sprite_on, anim_done;
    logic [1:0]  frame_idx;

    sprite_anim_renderer dut (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY),
        .blank(blank), .vsync(vsync), .play(play), .loop(loop), .flip(flip),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue),
        .sprite_on(sprite_on), .frame_idx(frame_idx), .anim_done(anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    // rom_addr is the ROM's address register, so data follows it within the cycle.
    logic [3:0] rom_mem [0:8191];
    initial for (int i = 0; i < 8192; i++) rom_mem[i] = 4'(i % 16);
    assign rom_q     = rom_mem[rom_addr];
    assign pal_red   = pal_index;
    assign pal_green = ~pal_index;
    assign pal_blue  = pal_index ^ 4'h5;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int due; logic [12:0] addr; } addr_exp_t;
    typedef struct { int due; logic on; logic [3:0] r, g, b; } pix_exp_t;
    addr_exp_t addr_q[$];
    pix_exp_t  pix_q[$];

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic in_box, input int a);
        addr_exp_t ae;
        pix_exp_t  pe;
        logic [3:0] idx;
        @(negedge vga_clk);
        DrawX = x; DrawY = y; blank = b;
        ae.due  = cyc + 1;
        ae.addr = in_box ? 13'(a) : 13'd0;
        addr_q.push_back(ae);
        idx     = 4'(a % 16);
        pe.due  = cyc + 2;
        pe.on   = in_box && b && (idx != 4'd0);
        pe.r    = pe.on ? idx : 4'd0;
        pe.g    = pe.on ? ~idx : 4'd0;
        pe.b    = pe.on ? (idx ^ 4'h5) : 4'd0;
        pix_q.push_back(pe);
    endtask

    always @(negedge vga_clk) begin
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            addr_exp_t e;
            e = addr_q.pop_front();
            if (e.due < cyc) check("addr_stale", e.due, cyc);
            else             check("rom_addr", rom_addr, e.addr);
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pix_exp_t e;
            e = pix_q.pop_front();
            if (e.due < cyc) begin
                check("pix_stale", e.due, cyc);
            end else begin
                check("sprite_on", sprite_on, e.on);
                check("rgb", {red, green, blue}, {e.r, e.g, e.b});
            end
        end
    end

    task automatic vs_pulse();
        @(negedge vga_clk) vsync = 1'b1;
        @(negedge vga_clk) vsync = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge vga_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; SprX = 10'd100; SprY = 10'd50;
        blank = 1'b1; vsync = 1'b0; play = 1'b0; loop = 1'b0; flip = 1'b0;
        repeat (2) @(negedge vga_clk);
        check("rst_frame", frame_idx, 0);
        check("rst_done", anim_done, 0);
        check("rst_on", sprite_on, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_pal", pal_index, 0);
        reset = 1'b0;

        // Row scan across the sprite and one pixel either side.
        for (int x = 99; x <= 140; x++)
            drive(10'(x), 10'd50, 1'b1, (x >= 100 && x <= 139), x - 100);
        drain();

        // Flip is latched only on vsync rise.
        flip = 1'b1;
        drive(10'd100, 10'd50, 1'b1, 1'b1, 0);
        drive(10'd139, 10'd50, 1'b1, 1'b1, 39);
        vs_pulse();
        drive(10'd100, 10'd50, 1'b1, 1'b1, 39);
        drive(10'd139, 10'd50, 1'b1, 1'b1, 0);
        drive(10'd110, 10'd50, 1'b1, 1'b1, 29);
        drain();
        flip = 1'b0;
        vs_pulse();

        // Looping animation over 30 vsync pulses.
        play = 1'b1; loop = 1'b1;
        repeat (2) @(negedge vga_clk);
        for (int p = 1; p <= 30; p++) begin
            vs_pulse();
            check("loop_frame", frame_idx, (p / 6) % 4);
            if (p == 12) begin
                drive(10'd100, 10'd50, 1'b1, 1'b1, 3200);
                drive(10'd101, 10'd50, 1'b1, 1'b1, 3201);
            end
        end
        check("loop_done", anim_done, 0);
        drain();
        play = 1'b0;
        @(negedge vga_clk);
        check("stop_frame", frame_idx, 0);

        // One-shot: reaches DONE after 24 pulses, loop=1 in DONE does not restart.
        loop = 1'b0; play = 1'b1;
        repeat (2) @(negedge vga_clk);
        for (int p = 1; p <= 24; p++) begin
            vs_pulse();
            if (p == 23) begin
                check("os23_frame", frame_idx, 3);
                check("os23_done", anim_done, 0);
            end
        end
        check("os_frame", frame_idx, 3);
        check("os_done", anim_done, 1);
        loop = 1'b1;
        for (int p = 0; p < 10; p++) begin
            vs_pulse();
            check("hold_frame", frame_idx, 3);
            check("hold_done", anim_done, 1);
        end
        play = 1'b0; loop = 1'b0;
        @(negedge vga_clk);
        check("idle_frame", frame_idx, 0);
        check("idle_done", anim_done, 0);

        // Clipping at the right edge and the left/top/bottom boundaries.
        SprX = 10'd620;
        drive(10'd619, 10'd50, 1'b1, 1'b0, 0);
        drive(10'd620, 10'd50, 1'b1, 1'b1, 0);
        drive(10'd625, 10'd50, 1'b1, 1'b1, 5);
        drive(10'd639, 10'd50, 1'b1, 1'b1, 19);
        drive(10'd0,   10'd50, 1'b1, 1'b0, 0);
        drain();
        SprX = 10'd0;
        drive(10'd0,  10'd50, 1'b1, 1'b1, 0);
        drive(10'd1,  10'd50, 1'b1, 1'b1, 1);
        drive(10'd39, 10'd50, 1'b1, 1'b1, 39);
        drive(10'd40, 10'd50, 1'b1, 1'b0, 0);
        drive(10'd5,  10'd50, 1'b0, 1'b1, 5);
        drive(10'd3,  10'd89, 1'b1, 1'b1, 1563);
        drive(10'd3,  10'd90, 1'b1, 1'b0, 0);
        drive(10'd3,  10'd49, 1'b1, 1'b0, 0);
        drain();

        // Reset mid-animation with an opaque pixel in flight.
        SprX = 10'd100; play = 1'b1; loop = 1'b1;
        repeat (2) @(negedge vga_clk);
        repeat (12) vs_pulse();
        check("pre_rst_frame", frame_idx, 2);
        @(negedge vga_clk);
        DrawX = 10'd105; DrawY = 10'd50; blank = 1'b1;
        @(negedge vga_clk) reset = 1'b1;
        @(negedge vga_clk);
        check("mid_rst_on", sprite_on, 0);
        check("mid_rst_rgb", {red, green, blue}, 0);
        check("mid_rst_frame", frame_idx, 0);
        check("mid_rst_done", anim_done, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_pal", pal_index, 0);
        reset = 1'b0; play = 1'b0;
        drive(10'd105, 10'd50, 1'b1, 1'b1, 5);
        drive(10'd106, 10'd50, 1'b1, 1'b1, 6);
        drain();

        check("sb_empty", addr_q.size() + pix_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
Generalised sprite pixel engine for the VGA path. It places a SPR_W x SPR_H sprite at (SprX, SprY) and selects one of FRAMES animation frames stored back-to-back in an external sprite ROM. Frames advance on a vsync-driven timer, with one-shot or loop mode and horizontal flip; transparent pixels are keyed out. Its RGB and sprite_on outputs feed the per-pixel layer mux ahead of the VGA DAC.

Parameters:
SPR_W, 40, sprite width in pixels (1..640)
SPR_H, 40, sprite height in pixels (1..480)
FRAMES, 4, number of animation frames in ROM (>=1)
FRAME_TICKS, 6, vsync rising edges per animation frame (>=1)
ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H
PIX_W, 4, ROM palette-index width
TRANSPARENT_IDX, 0, palette index treated as transparent

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset  in  1  synchronous, active-high
DrawX, DrawY  in  10  current pixel coordinate
SprX, SprY  in  10  sprite top-left coordinate
blank  in  1  1 = active video
vsync  in  1  VGA vsync level
play  in  1  1 = run animation, 0 = return to frame 0
loop  in  1  1 = wrap after last frame, 0 = one-shot
flip  in  1  1 = mirror horizontally
rom_addr  out  ADDR_W  address to sprite ROM (synchronous, 1-cycle read latency, posedge vga_clk)
rom_q  in  PIX_W  ROM data for the address presented on the previous cycle
pal_index  out  PIX_W  registered index to the combinational palette
pal_red, pal_green, pal_blue  in  4  palette outputs for pal_index
red, green, blue  out  4  pixel colour
sprite_on  out  1  1 = opaque sprite pixel on this output cycle
frame_idx  out  clog2(FRAMES) (min 1)  current animation frame
anim_done  out  1  1 while in DONE state

Behaviour:
- Reset (synchronous): state IDLE, frame_idx 0, tick counter 0, flip_lat 0, vsync_d 0, rom_addr 0, pal_index 0, red/green/blue 0, sprite_on 0, anim_done 0, all pipeline valid bits 0.
- vsync edge: vs_rise = vsync & ~vsync_d (vsync_d registered). On vs_rise, flip_lat <= flip; flip therefore never changes mid-frame.
- FSM, evaluated every cycle:
  - IDLE: frame_idx 0, tick 0. If play=1, go to PLAY.
  - PLAY: if play=0, go to IDLE, clearing frame and tick the same cycle; play=0 has priority over vs_rise. Otherwise on vs_rise: if tick == FRAME_TICKS-1, clear tick and advance the frame; else tick+1. Advancing from frame FRAMES-1 goes to frame 0 if loop=1, else the frame is held and the FSM goes to DONE.
  - DONE: frame held at FRAMES-1, anim_done=1. If play=0, go to IDLE. loop going high in DONE does not restart the animation.
  - FRAMES=1: the frame never changes. One-shot reaches DONE after FRAME_TICKS edges.
- Stage 0 (combinational, from the DrawX/DrawY inputs):
  - lx = DrawX-SprX and ly = DrawY-SprY, computed 11 bits wide.
  - in_box = (DrawX >= SprX) && (DrawX-SprX < SPR_W) && (DrawY >= SprY) && (DrawY-SprY < SPR_H). Computed without overflow; a sprite partly off-screen clips correctly.
  - cx = flip_lat ? SPR_W-1-lx : lx.
- Stage 1 (registered): rom_addr <= in_box ? frame_idx*SPR_W*SPR_H + ly*SPR_W + cx : 0. in_box and blank are delayed in step to v1 and b1.
- Stage 2 (registered):
  - pal_index <= rom_q.
  - Opaque (v2) <= v1 && rom_q != TRANSPARENT_IDX; blank delayed to b2.
- Output:
  - red/green/blue are driven combinationally from the palette, gated by (v2 && b2); otherwise 0.
  - sprite_on = v2 && b2.
  - Total latency from DrawX/DrawY to red/green/blue and sprite_on: 2 vga_clk cycles. The upstream mux must delay its background path by 2.
- A frame_idx change mid-line affects only pixels sampled after the change. frame_idx is intended to change only at vs_rise.
- A reset mid-line forces all outputs to 0 on the next edge; the pipeline refills within 2 cycles.

Test Plan:
- Spr=(100,50), play=0, DrawX=100..139, DrawY=50; ROM filled with addr%16 (index 0 transparent) -> rom_addr 0..39. sprite_on=1 two cycles after each input except where addr%16==0. DrawX=99 and 140 give sprite_on=0 and rgb=0.
- flip=1 asserted mid-frame -> addresses unchanged until the next vs_rise, then DrawX=100 gives rom_addr 39 and DrawX=139 gives rom_addr 0.
- play=1, loop=1, FRAMES=4, FRAME_TICKS=6, 30 vsync pulses -> frame_idx steps 0,1,2,3,0 every 6 pulses. frame 2 at DrawX=100, DrawY=50 gives rom_addr 3200.
- play=1, loop=0 -> after 24 pulses frame_idx=3, anim_done=1, held through 10 more pulses; play=0 -> next cycle IDLE, frame_idx 0, anim_done 0.
- SprX=620 (partly off right edge) and DrawX=0 with SprX=0 -> DrawX 620..639 in box, no wrap. blank=0 in box -> rgb 0, sprite_on 0.
- reset=1 mid-animation at frame 2 -> next cycle frame_idx 0, rgb 0, sprite_on 0, state IDLE.
